// File: rtl/decode_stage_fwd_pkg.sv
// Decode-stage constants: MIPS opcode/funct encodings and register-address width helper.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;

    // Address width for a power-of-two register count; never narrower than one bit.
    function automatic int reg_addr_w(input int numRegs);
        int w;
        w = 0;
        while ((1 << w) < numRegs) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decode_stage_fwd_if.sv
// Fetch/execute handshake, forwarding sources and writeback bus seen by the decode stage.
interface decode_stage_fwd_if
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int FWD_PORTS = 2,
    parameter int CNT_W     = 32
);
    localparam int AW = reg_addr_w(NUM_REGS);

    logic                      if_valid;
    logic [31:0]               if_instruction;
    logic [XLEN-1:0]           if_pc;
    logic                      if_ready;
    logic                      flush;
    logic [FWD_PORTS-1:0]      fwd_valid;
    logic [FWD_PORTS-1:0]      fwd_isLoad;
    logic [FWD_PORTS*AW-1:0]   fwd_address;
    logic [FWD_PORTS*XLEN-1:0] fwd_data;
    logic                      wb_shouldWriteRegister;
    logic [AW-1:0]             wb_registerWriteAddress;
    logic [XLEN-1:0]           wb_registerWriteData;
    logic                      ex_ready;
    logic                      ex_valid;
    logic [31:0]               ex_instruction;
    logic [XLEN-1:0]           ex_pc;
    logic [XLEN-1:0]           ex_registerRs;
    logic [XLEN-1:0]           ex_registerRt;
    logic [XLEN-1:0]           ex_immediate;
    logic [CNT_W-1:0]          stallCycles;

    // Surrounding pipeline (fetch, later stages, writeback).
    modport master (
        output if_valid, if_instruction, if_pc, flush,
        output fwd_valid, fwd_isLoad, fwd_address, fwd_data,
        output wb_shouldWriteRegister, wb_registerWriteAddress, wb_registerWriteData,
        output ex_ready,
        input  if_ready, ex_valid, ex_instruction, ex_pc,
        input  ex_registerRs, ex_registerRt, ex_immediate, stallCycles
    );

    // Decode stage.
    modport slave (
        input  if_valid, if_instruction, if_pc, flush,
        input  fwd_valid, fwd_isLoad, fwd_address, fwd_data,
        input  wb_shouldWriteRegister, wb_registerWriteAddress, wb_registerWriteData,
        input  ex_ready,
        output if_ready, ex_valid, ex_instruction, ex_pc,
        output ex_registerRs, ex_registerRt, ex_immediate, stallCycles
    );

endinterface

// File: rtl/decode_stage_fwd_regfile_2r1w.sv
// Architectural register file: two combinational reads, one write, r0 hard-wired to zero.
module regfile_2r1w
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = reg_addr_w(NUM_REGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rdAddrA,
    input  logic [AW-1:0]   rdAddrB,
    output logic [XLEN-1:0] rdDataA,
    output logic [XLEN-1:0] rdDataB,
    input  logic            wrEn,
    input  logic [AW-1:0]   wrAddr,
    input  logic [XLEN-1:0] wrData
);
    logic [XLEN-1:0] mem [NUM_REGS];
    logic            wrLive;

    assign wrLive = wrEn && (wrAddr != '0);

    // Reads see a same-cycle write so decode never picks up a stale value.
    assign rdDataA = (wrLive && (wrAddr == rdAddrA)) ? wrData : mem[rdAddrA];
    assign rdDataB = (wrLive && (wrAddr == rdAddrB)) ? wrData : mem[rdAddrB];

    // Storage; mem[0] is never written so it stays zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wrLive) begin
            mem[wrAddr] <= wrData;
        end
    end

endmodule

// File: rtl/decode_stage_fwd.sv
// MIPS decode stage: IF/ID and ID/EX registers, operand forwarding, load-use stall, flush.
module decode_stage_fwd
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int FWD_PORTS = 2,
    parameter int CNT_W     = 32
) (
    input logic               clock,
    input logic               reset,
    decode_stage_fwd_if.slave bus
);
    localparam int AW = reg_addr_w(NUM_REGS);

    logic                 idValid;
    logic [31:0]          idInst;
    logic [XLEN-1:0]      idPc;

    logic                 exValid;
    logic [31:0]          exInst;
    logic [XLEN-1:0]      exPc, exRs, exRt, exImm;
    logic [CNT_W-1:0]     stallCnt;

    logic [5:0]           opcode, funct;
    logic [AW-1:0]        rsAddr, rtAddr;
    logic [15:0]          imm16;
    logic                 rsUsed, rtUsed, isShift;
    logic [FWD_PORTS-1:0] loadHit, rsFwdHit, rtFwdHit;
    logic                 hazard, advance, ifReady;
    logic [XLEN-1:0]      rfRs, rfRt, rsVal, rtVal, immExt;

    assign opcode  = idInst[31:26];
    assign funct   = idInst[5:0];
    assign rsAddr  = idInst[21 +: AW];
    assign rtAddr  = idInst[16 +: AW];
    assign imm16   = idInst[15:0];

    assign isShift = (opcode == OP_RTYPE) &&
                     ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
    assign rsUsed  = !((opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_LUI) || isShift);
    assign rtUsed  = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);

    // Per-source comparators: pending-load hazard and ready-result forwarding hits.
    for (genvar i = 0; i < FWD_PORTS; i++) begin : g_fwd
        logic [AW-1:0] srcAddr;
        assign srcAddr     = bus.fwd_address[i*AW +: AW];
        assign loadHit[i]  = bus.fwd_valid[i] && bus.fwd_isLoad[i] && (srcAddr != '0) &&
                             ((rsUsed && (srcAddr == rsAddr)) || (rtUsed && (srcAddr == rtAddr)));
        assign rsFwdHit[i] = bus.fwd_valid[i] && !bus.fwd_isLoad[i] && (srcAddr == rsAddr);
        assign rtFwdHit[i] = bus.fwd_valid[i] && !bus.fwd_isLoad[i] && (srcAddr == rtAddr);
    end

    assign hazard  = idValid && (|loadHit);
    assign advance = idValid && !hazard && bus.ex_ready;
    assign ifReady = !bus.flush && (!idValid || advance);

    regfile_2r1w #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .AW(AW)) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .rdAddrA (rsAddr),
        .rdAddrB (rtAddr),
        .rdDataA (rfRs),
        .rdDataB (rfRt),
        .wrEn    (bus.wb_shouldWriteRegister),
        .wrAddr  (bus.wb_registerWriteAddress),
        .wrData  (bus.wb_registerWriteData)
    );

    // Operand priority: r0, youngest forwarding source, WB write-through (inside regfile), array.
    always_comb begin
        rsVal = rfRs;
        rtVal = rfRt;
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (rsFwdHit[i]) rsVal = bus.fwd_data[i*XLEN +: XLEN];
            if (rtFwdHit[i]) rtVal = bus.fwd_data[i*XLEN +: XLEN];
        end
        if (rsAddr == '0) rsVal = '0;
        if (rtAddr == '0) rtVal = '0;
    end

    // Immediate: logical ops zero-extend, lui shifts into the upper half, everything else sign-extends.
    always_comb begin
        immExt = {{(XLEN-16){imm16[15]}}, imm16};
        if (opcode == OP_LUI) begin
            immExt = XLEN'({imm16, 16'h0000});
        end else if ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI)) begin
            immExt = XLEN'(imm16);
        end
    end

    // IF/ID register: flush wins, then accept a fetch beat, else empty on advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idValid <= 1'b0;
            idInst  <= '0;
            idPc    <= '0;
        end else if (bus.flush) begin
            idValid <= 1'b0;
        end else if (bus.if_valid && ifReady) begin
            idValid <= 1'b1;
            idInst  <= bus.if_instruction;
            idPc    <= bus.if_pc;
        end else if (advance) begin
            idValid <= 1'b0;
        end
    end

    // ID/EX register: holds while execute stalls; a flush only kills the beat execute would take.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exValid <= 1'b0;
            exInst  <= '0;
            exPc    <= '0;
            exRs    <= '0;
            exRt    <= '0;
            exImm   <= '0;
        end else if (bus.ex_ready) begin
            if (bus.flush) begin
                exValid <= 1'b0;
            end else if (advance) begin
                exValid <= 1'b1;
                exInst  <= idInst;
                exPc    <= idPc;
                exRs    <= rsVal;
                exRt    <= rtVal;
                exImm   <= immExt;
            end else begin
                exValid <= 1'b0;
            end
        end
    end

    // Load-use stall counter, saturating.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
        end else if (hazard && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign bus.if_ready       = ifReady;
    assign bus.ex_valid       = exValid;
    assign bus.ex_instruction = exInst;
    assign bus.ex_pc          = exPc;
    assign bus.ex_registerRs  = exRs;
    assign bus.ex_registerRt  = exRt;
    assign bus.ex_immediate   = exImm;
    assign bus.stallCycles    = stallCnt;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Directed bench for decode_stage_fwd with hand-computed expectations.
module tb_decode_stage_fwd;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NFWD = 2;
    localparam int CW   = 4;
    localparam int AWT  = 5;

    logic clock;
    logic reset;
    int   nCompared;
    int   nMismatched;

    decode_stage_fwd_if #(.XLEN(XLEN), .NUM_REGS(NREG), .FWD_PORTS(NFWD), .CNT_W(CW)) bus ();

    decode_stage_fwd #(.XLEN(XLEN), .NUM_REGS(NREG), .FWD_PORTS(NFWD), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic setFwd(input int port, input logic v, input logic ld, input int addr, input logic [31:0] data);
        bus.fwd_valid[port]              = v;
        bus.fwd_isLoad[port]             = ld;
        bus.fwd_address[port*AWT +: AWT] = 5'(addr);
        bus.fwd_data[port*XLEN +: XLEN]  = data;
    endtask

    task automatic clearFwd();
        bus.fwd_valid   = '0;
        bus.fwd_isLoad  = '0;
        bus.fwd_address = '0;
        bus.fwd_data    = '0;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
        bus.if_valid       = 1'b1;
        bus.if_instruction = inst;
        bus.if_pc          = pc;
        step();
        bus.if_valid       = 1'b0;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_instruction = '0;
        bus.if_pc = '0;
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        bus.wb_shouldWriteRegister = 1'b0;
        bus.wb_registerWriteAddress = '0;
        bus.wb_registerWriteData = '0;
        clearFwd();

        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        step();
        checkVal("rst_ex_valid", bus.ex_valid, 0);
        checkVal("rst_stall", bus.stallCycles, 0);
        checkVal("rst_ex_inst", bus.ex_instruction, 0);
        checkVal("rst_if_ready", bus.if_ready, 1);

        // Both sources match r1: port 0 wins.
        fetch(rtype(1, 2, 3, 6'h20), 32'h100);
        setFwd(0, 1, 0, 1, 32'h11);
        setFwd(1, 1, 0, 1, 32'h22);
        step();
        checkVal("fwd_ex_valid", bus.ex_valid, 1);
        checkVal("fwd_ex_pc", bus.ex_pc, 32'h100);
        checkVal("fwd_ex_inst", bus.ex_instruction, 32'h00221820);
        checkVal("fwd_port0_rs", bus.ex_registerRs, 32'h11);
        checkVal("fwd_rt_rf", bus.ex_registerRt, 0);
        clearFwd();

        // Only port 1 matches r2.
        fetch(rtype(2, 2, 4, 6'h20), 32'h104);
        setFwd(0, 1, 0, 9, 32'h99);
        setFwd(1, 1, 0, 2, 32'h22);
        step();
        checkVal("fwd_port1_rs", bus.ex_registerRs, 32'h22);
        checkVal("fwd_port1_rt", bus.ex_registerRt, 32'h22);
        clearFwd();
        step();
        checkVal("bubble_ex_valid", bus.ex_valid, 0);

        // Load-use: one stall then forwarding from MEM.
        fetch(rtype(5, 0, 6, 6'h20), 32'h110);
        setFwd(0, 1, 1, 5, 32'hBAD);
        #1;
        checkVal("lu_if_ready", bus.if_ready, 0);
        step();
        checkVal("lu_bubble", bus.ex_valid, 0);
        checkVal("lu_stall1", bus.stallCycles, 1);
        clearFwd();
        setFwd(1, 1, 0, 5, 32'h55);
        step();
        checkVal("lu_ex_valid", bus.ex_valid, 1);
        checkVal("lu_rs_mem", bus.ex_registerRs, 32'h55);
        checkVal("lu_stall_hold", bus.stallCycles, 1);
        clearFwd();

        // sll does not read rs: a load to the rs field is no hazard.
        fetch(rtype(5, 2, 1, 6'h00), 32'h114);
        setFwd(0, 1, 1, 5, 32'hBAD);
        step();
        checkVal("sll_ex_valid", bus.ex_valid, 1);
        checkVal("sll_ex_pc", bus.ex_pc, 32'h114);
        checkVal("sll_stall", bus.stallCycles, 1);
        clearFwd();

        // WB write-through, then writes to r0 ignored.
        fetch(rtype(7, 0, 8, 6'h20), 32'h120);
        bus.wb_shouldWriteRegister = 1'b1;
        bus.wb_registerWriteAddress = 5'd7;
        bus.wb_registerWriteData = 32'hDEAD;
        step();
        checkVal("wb_thru_rs", bus.ex_registerRs, 32'hDEAD);
        bus.wb_registerWriteAddress = 5'd0;
        bus.wb_registerWriteData = 32'hBEEF;
        fetch(rtype(0, 7, 9, 6'h20), 32'h124);
        step();
        checkVal("wb_r0_rs", bus.ex_registerRs, 0);
        checkVal("wb_rf_rt", bus.ex_registerRt, 32'hDEAD);
        bus.wb_shouldWriteRegister = 1'b0;
        fetch(rtype(0, 0, 10, 6'h20), 32'h128);
        step();
        checkVal("r0_rt", bus.ex_registerRt, 0);

        // Flush kills IF/ID and drops the fetch beat.
        fetch(rtype(1, 2, 3, 6'h20), 32'h200);
        bus.if_valid = 1'b1;
        bus.if_instruction = rtype(1, 2, 4, 6'h20);
        bus.if_pc = 32'h204;
        bus.flush = 1'b1;
        #1;
        checkVal("fl_if_ready", bus.if_ready, 0);
        step();
        bus.flush = 1'b0;
        bus.if_valid = 1'b0;
        checkVal("fl_ex_valid", bus.ex_valid, 0);
        #1;
        checkVal("fl_id_empty", bus.if_ready, 1);
        step();
        checkVal("fl_dropped", bus.ex_valid, 0);

        // Execute backpressure and immediates.
        bus.if_valid = 1'b1;
        bus.if_instruction = itype(6'h0D, 0, 11, 16'hFFFF);
        bus.if_pc = 32'h300;
        step();
        bus.if_instruction = itype(6'h08, 0, 12, 16'hFFFF);
        bus.if_pc = 32'h304;
        step();
        checkVal("ori_imm", bus.ex_immediate, 32'h0000FFFF);
        checkVal("ori_pc", bus.ex_pc, 32'h300);
        bus.ex_ready = 1'b0;
        bus.if_instruction = itype(6'h0F, 0, 13, 16'h1234);
        bus.if_pc = 32'h308;
        #1;
        checkVal("bp_if_ready", bus.if_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkVal("bp_ex_pc_hold", bus.ex_pc, 32'h300);
        end
        checkVal("bp_ex_valid", bus.ex_valid, 1);
        checkVal("bp_imm_hold", bus.ex_immediate, 32'h0000FFFF);
        bus.ex_ready = 1'b1;
        step();
        bus.if_valid = 1'b0;
        checkVal("addi_pc", bus.ex_pc, 32'h304);
        checkVal("addi_imm", bus.ex_immediate, 32'hFFFFFFFF);
        step();
        checkVal("lui_pc", bus.ex_pc, 32'h308);
        checkVal("lui_imm", bus.ex_immediate, 32'h12340000);
        step();
        checkVal("bp_drain", bus.ex_valid, 0);

        // Long load-use stall: counter saturates at all-ones (1 + 20 -> 15).
        fetch(rtype(5, 0, 6, 6'h20), 32'h140);
        setFwd(0, 1, 1, 5, 32'h0);
        repeat (20) step();
        checkVal("sat_stall", bus.stallCycles, 4'hF);
        checkVal("sat_ex_valid", bus.ex_valid, 0);
        clearFwd();
        step();
        checkVal("sat_release_pc", bus.ex_pc, 32'h140);
        checkVal("sat_release_v", bus.ex_valid, 1);

        // Asynchronous reset mid-stream.
        fetch(rtype(7, 0, 8, 6'h20), 32'h150);
        #2 reset = 1'b0;
        #1;
        checkVal("arst_ex_valid", bus.ex_valid, 0);
        checkVal("arst_ex_pc", bus.ex_pc, 0);
        checkVal("arst_ex_rs", bus.ex_registerRs, 0);
        checkVal("arst_stall", bus.stallCycles, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        step();
        checkVal("arst_if_ready", bus.if_ready, 1);
        checkVal("arst_ex_valid2", bus.ex_valid, 0);
        fetch(rtype(7, 0, 8, 6'h20), 32'h160);
        step();
        checkVal("arst_rf_clear", bus.ex_registerRs, 0);
        checkVal("arst_new_pc", bus.ex_pc, 32'h160);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
